// File: rtl/gigatron_out_stage_if.sv
// gigatron_out_stage_if
//   CPU-to-output-stage write bus. The CPU side (master) presents one OUT
//   write per cycle; the output stage (slave) never back-pressures it.
//   i_Out_Valid : an OUT-destination instruction executes this cycle
//   i_Out_Data  : ALU result being written to OUT
//   i_Acc       : accumulator before the current instruction (XOUT source)
interface gigatron_out_stage_if;
  logic       i_Out_Valid;
  logic [7:0] i_Out_Data;
  logic [7:0] i_Acc;

  modport master (output i_Out_Valid, output i_Out_Data, output i_Acc);
  modport slave  (input  i_Out_Valid, input  i_Out_Data, input  i_Acc);
endinterface

// File: rtl/gigatron_out_stage.sv
// gigatron_out_stage
//   Captures Gigatron OUT-port writes, latches XOUT on the hsync rising edge,
//   drives the VGA pins and LEDs, and measures video-loop health:
//   lines per frame, OUT writes per line, and an hsync-loss watchdog.
//   Ports:
//     i_Clk, i_Rst_L   clock, asynchronous active-low reset
//     out_bus          OUT write bus (valid / data / accumulator)
//     o_VGA_*          sync pins and 2->3 bit expanded colour
//     o_Leds           XOUT[3:0]
//     o_Line_Count     hsync falling edges in the last complete frame
//     o_Line_Writes    OUT writes in the last complete line
//     o_Frame_Toggle   inverts on every vsync falling edge
//     o_Sync_Lost      no hsync falling edge for more than SYNC_TIMEOUT clocks
module gigatron_out_stage #(
  parameter int unsigned SYNC_TIMEOUT = 1024  // legal range 2..65535
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst_L,
  gigatron_out_stage_if.slave         out_bus,
  output logic                        o_VGA_HSync,
  output logic                        o_VGA_VSync,
  output logic [2:0]                  o_VGA_Red,
  output logic [2:0]                  o_VGA_Grn,
  output logic [2:0]                  o_VGA_Blu,
  output logic [3:0]                  o_Leds,
  output logic [9:0]                  o_Line_Count,
  output logic [7:0]                  o_Line_Writes,
  output logic                        o_Frame_Toggle,
  output logic                        o_Sync_Lost
);

  localparam logic [15:0] WD_LIMIT  = 16'(SYNC_TIMEOUT);
  localparam logic [9:0]  LINE_MAX  = '1;
  localparam logic [7:0]  WRITE_MAX = '1;

  logic [7:0]  out_q;
  logic [3:0]  xout_q;   // only the LED nibble of XOUT is observable
  logic [9:0]  line_cnt;
  logic [7:0]  wcnt;
  logic [15:0] wd_cnt;

  logic hfall, hrise, vfall;

  // Edges compare the held OUT value against the value being written now,
  // so a write that leaves a sync bit unchanged produces no edge.
  always_comb begin
    hfall = out_bus.i_Out_Valid &  out_q[6] & ~out_bus.i_Out_Data[6];
    hrise = out_bus.i_Out_Valid & ~out_q[6] &  out_bus.i_Out_Data[6];
    vfall = out_bus.i_Out_Valid &  out_q[7] & ~out_bus.i_Out_Data[7];
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      out_q          <= 8'hC0;
      xout_q         <= '0;
      line_cnt       <= '0;
      wcnt           <= '0;
      wd_cnt         <= '0;
      o_Line_Count   <= '0;
      o_Line_Writes  <= '0;
      o_Frame_Toggle <= 1'b0;
      o_Sync_Lost    <= 1'b1;
    end else begin
      if (out_bus.i_Out_Valid) out_q <= out_bus.i_Out_Data;

      if (hrise) xout_q <= out_bus.i_Acc[3:0];

      // An hfall in the same write as vfall is the first line of the new frame.
      if (vfall) begin
        o_Line_Count   <= line_cnt;
        line_cnt       <= hfall ? 10'd1 : 10'd0;
        o_Frame_Toggle <= ~o_Frame_Toggle;
      end else if (hfall && line_cnt != LINE_MAX) begin
        line_cnt <= line_cnt + 10'd1;
      end

      // The hfall write itself is the first write of the new line.
      if (hfall) begin
        o_Line_Writes <= wcnt;
        wcnt          <= 8'd1;
      end else if (out_bus.i_Out_Valid && wcnt != WRITE_MAX) begin
        wcnt <= wcnt + 8'd1;
      end

      if (hfall) begin
        wd_cnt      <= '0;
        o_Sync_Lost <= 1'b0;
      end else if (wd_cnt == WD_LIMIT) begin
        o_Sync_Lost <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + 16'd1;
      end
    end
  end

  assign o_VGA_HSync = out_q[6];
  assign o_VGA_VSync = out_q[7];
  assign o_VGA_Red   = {out_q[1], out_q[0], out_q[1]};
  assign o_VGA_Grn   = {out_q[3], out_q[2], out_q[3]};
  assign o_VGA_Blu   = {out_q[5], out_q[4], out_q[5]};
  assign o_Leds      = xout_q;

endmodule

// File: tb/tb_gigatron_out_stage.sv
// tb_gigatron_out_stage
//   Scoreboard bench: each driven cycle pushes the expected outputs from a
//   small behavioural model; the entry is popped and compared once the
//   following clock edge has registered the write. Directed checks cover the
//   specific values called out for each scenario.
module tb_gigatron_out_stage;

  localparam int unsigned TO = 16;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
    logic [3:0] leds;
    logic [9:0] lc;
    logic [7:0] lw;
    logic       ft;
    logic       lost;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gigatron_out_stage_if bus ();

  logic       hs, vs, ft, lost;
  logic [2:0] red, grn, blu;
  logic [3:0] leds;
  logic [9:0] lc;
  logic [7:0] lw;

  gigatron_out_stage #(.SYNC_TIMEOUT(TO)) dut (
    .i_Clk          (clk),
    .i_Rst_L        (rst_n),
    .out_bus        (bus),
    .o_VGA_HSync    (hs),
    .o_VGA_VSync    (vs),
    .o_VGA_Red      (red),
    .o_VGA_Grn      (grn),
    .o_VGA_Blu      (blu),
    .o_Leds         (leds),
    .o_Line_Count   (lc),
    .o_Line_Writes  (lw),
    .o_Frame_Toggle (ft),
    .o_Sync_Lost    (lost)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  exp_t sb_q[$];

  // reference model state
  logic [7:0]  m_out;
  logic [3:0]  m_xout;
  logic [9:0]  m_lcnt, m_lc;
  logic [7:0]  m_wcnt, m_lw;
  logic [15:0] m_wd;
  logic        m_ft, m_lost;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    e.hs   = m_out[6];
    e.vs   = m_out[7];
    e.r    = {m_out[1], m_out[0], m_out[1]};
    e.g    = {m_out[3], m_out[2], m_out[3]};
    e.b    = {m_out[5], m_out[4], m_out[5]};
    e.leds = m_xout;
    e.lc   = m_lc;
    e.lw   = m_lw;
    e.ft   = m_ft;
    e.lost = m_lost;
    return e;
  endfunction

  task automatic compare_outputs(input string ph, input exp_t e);
    check_eq({ph, ".hsync"},  32'(hs),   32'(e.hs));
    check_eq({ph, ".vsync"},  32'(vs),   32'(e.vs));
    check_eq({ph, ".red"},    32'(red),  32'(e.r));
    check_eq({ph, ".grn"},    32'(grn),  32'(e.g));
    check_eq({ph, ".blu"},    32'(blu),  32'(e.b));
    check_eq({ph, ".leds"},   32'(leds), 32'(e.leds));
    check_eq({ph, ".lcount"}, 32'(lc),   32'(e.lc));
    check_eq({ph, ".lwrites"},32'(lw),   32'(e.lw));
    check_eq({ph, ".ftog"},   32'(ft),   32'(e.ft));
    check_eq({ph, ".lost"},   32'(lost), 32'(e.lost));
  endtask

  task automatic model_reset();
    m_out = 8'hC0; m_xout = '0; m_lcnt = '0; m_lc = '0;
    m_wcnt = '0; m_lw = '0; m_wd = '0; m_ft = 1'b0; m_lost = 1'b1;
    sb_q.delete();
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic [7:0] a);
    logic hf, hr, vf;
    hf = v && m_out[6] && !d[6];
    hr = v && !m_out[6] && d[6];
    vf = v && m_out[7] && !d[7];
    if (hr) m_xout = a[3:0];
    if (vf) begin
      m_lc   = m_lcnt;
      m_lcnt = hf ? 10'd1 : 10'd0;
      m_ft   = ~m_ft;
    end else if (hf && m_lcnt != 10'd1023) begin
      m_lcnt = m_lcnt + 10'd1;
    end
    if (hf) begin
      m_lw   = m_wcnt;
      m_wcnt = 8'd1;
    end else if (v && m_wcnt != 8'd255) begin
      m_wcnt = m_wcnt + 8'd1;
    end
    if (hf) begin
      m_wd   = '0;
      m_lost = 1'b0;
    end else if (m_wd == 16'(TO)) begin
      m_lost = 1'b1;
    end else begin
      m_wd = m_wd + 16'd1;
    end
    if (v) m_out = d;
  endtask

  // Drive one cycle (called #1 after a rising edge), then score the result.
  task automatic cycle(input logic v, input logic [7:0] d, input logic [7:0] a);
    exp_t e;
    bus.i_Out_Valid = v;
    bus.i_Out_Data  = d;
    bus.i_Acc       = a;
    model_step(v, d, a);
    sb_q.push_back(model_outputs());
    @(posedge clk);
    #1;
    check_eq("sb_depth", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      compare_outputs("sb", e);
    end
  endtask

  task automatic wr(input logic [7:0] d, input logic [7:0] a = 8'h00);
    cycle(1'b1, d, a);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    exp_t rst_e;
    bus.i_Out_Valid = 1'b0;
    bus.i_Out_Data  = 8'h00;
    bus.i_Acc       = 8'h00;
    model_reset();
    rst_e = model_outputs();

    // reset values, held and after release
    repeat (3) @(posedge clk);
    #1;
    compare_outputs("rst_hold", rst_e);
    rst_n = 1'b1;
    idle(TO + 4);
    check_eq("rst_idle_lost", 32'(lost), 32'd1);
    check_eq("rst_idle_lc",   32'(lc),   32'd0);

    // pixel path: BB=10 GG=01 RR=11
    wr(8'hC0 | 8'h27);
    check_eq("pix_blu", 32'(blu), 32'b101);
    check_eq("pix_grn", 32'(grn), 32'b010);
    check_eq("pix_red", 32'(red), 32'b111);
    check_eq("pix_hs",  32'(hs),  32'd1);

    // XOUT capture on hsync rise only
    wr(8'h80, 8'h05);
    check_eq("xout_hfall", 32'(leds), 32'h0);
    wr(8'hC0, 8'h0A);
    check_eq("xout_hrise", 32'(leds), 32'hA);
    wr(8'hC0, 8'h03);
    check_eq("xout_hold",  32'(leds), 32'hA);

    // fresh frame: 3 lines of 10 writes, then vfall+hfall together
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_outputs("rst_async", model_outputs());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int unsigned ln = 0; ln < 3; ln++) begin
      wr(8'h80);
      for (int unsigned k = 0; k < 9; k++) wr(8'hC0 | 8'(k));
    end
    wr(8'h00);
    check_eq("frame_lw", 32'(lw), 32'd10);
    check_eq("frame_lc", 32'(lc), 32'd3);
    check_eq("frame_ft", 32'(ft), 32'd1);
    // restart at 1: one more hfall then a vfall without hfall gives 2
    wr(8'hC0);
    wr(8'h80);
    wr(8'hC0);
    wr(8'h40);
    check_eq("frame2_lc", 32'(lc), 32'd2);
    check_eq("frame2_ft", 32'(ft), 32'd0);

    // watchdog: hfall, then idle; flag rises SYNC_TIMEOUT+1 edges later
    wr(8'hC0);
    wr(8'h80);
    check_eq("wd_clear", 32'(lost), 32'd0);
    idle(TO);
    check_eq("wd_edge16", 32'(lost), 32'd0);
    idle(1);
    check_eq("wd_edge17", 32'(lost), 32'd1);
    idle(3);
    check_eq("wd_hold", 32'(lost), 32'd1);
    wr(8'hC0);
    check_eq("wd_hrise_only", 32'(lost), 32'd1);
    wr(8'h80);
    check_eq("wd_reclear", 32'(lost), 32'd0);

    // write counter saturation: 300 writes without hfall
    wr(8'hC0);
    for (int unsigned k = 0; k < 299; k++) wr(8'hC0 | 8'($urandom_range(0, 63)));
    wr(8'h80);
    check_eq("sat_lw", 32'(lw), 32'd255);

    // back-to-back random traffic through the scoreboard
    for (int unsigned k = 0; k < 200; k++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));

    // reset asserted mid-line, checked before the next edge
    wr(8'hC3, 8'h0F);
    wr(8'h83);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_outputs("rst_mid", model_outputs());
    check_eq("rst_mid_hs",   32'(hs),   32'd1);
    check_eq("rst_mid_lost", 32'(lost), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
